// File: rtl/input_debounce_8ch.sv
// input_debounce_8ch
//   Conditions 8 raw switch/button inputs into a clean request vector.
//   Per channel: 2-flop synchroniser, counter debouncer, registered
//   rise/fall pulses and a sticky request latch cleared by the host.
//
// Ports
//   clk        system clock (single domain)
//   rst        synchronous, active-high reset
//   raw_in     [7:0] asynchronous raw switch levels
//   clr        [7:0] per-channel clear of req_latch
//   db_out     [7:0] debounced level
//   rise       [7:0] 1-cycle pulse when db_out[i] goes 0->1
//   fall       [7:0] 1-cycle pulse when db_out[i] goes 1->0
//   req_latch  [7:0] sticky request, set by rise[i], cleared by clr[i]
//   any_req    OR of req_latch
module input_debounce_8ch #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] raw_in,
  input  logic [7:0] clr,
  output logic [7:0] db_out,
  output logic [7:0] rise,
  output logic [7:0] fall,
  output logic [7:0] req_latch,
  output logic       any_req
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  // Last count before acceptance; always representable in CNT_W bits.
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0]       s1_q, s2_q;
  logic [7:0]       db_q, db_d;
  logic [7:0]       rise_q, rise_d;
  logic [7:0]       fall_q, fall_d;
  logic [7:0]       req_q, req_d;
  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];

  always_comb begin
    db_d   = db_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          // Level held for the full window: accept it and emit the edge.
          db_d[i]   = s2_q[i];
          rise_d[i] = s2_q[i];
          fall_d[i] = ~s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    // Set uses the registered pulse so a clear in the pulse cycle loses.
    req_d = rise_q | (~clr & req_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= '0;
      s2_q   <= '0;
      db_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      req_q  <= '0;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q   <= raw_in;
      s2_q   <= s1_q;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      req_q  <= req_d;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign db_out    = db_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign req_latch = req_q;
  assign any_req   = |req_q;

endmodule

// File: tb/tb_input_debounce_8ch.sv
// Self-checking bench for input_debounce_8ch with DEBOUNCE_CYCLES=4.
// A behavioural model (run-length based) predicts outputs for every edge;
// predictions are queued when stimulus is driven and compared on the
// following falling edge. Directed spot checks cover the latency points.
module tb_input_debounce_8ch;

  localparam int unsigned D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] raw_in = '0;
  logic [7:0] clr = '0;
  logic [7:0] db_out, rise, fall, req_latch;
  logic       any_req;

  input_debounce_8ch #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .raw_in   (raw_in),
    .clr      (clr),
    .db_out   (db_out),
    .rise     (rise),
    .fall     (fall),
    .req_latch(req_latch),
    .any_req  (any_req)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] db;
    logic [7:0] ri;
    logic [7:0] fa;
    logic [7:0] rq;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model state.
  logic [7:0] m_s1, m_s2, m_db, m_rise, m_fall, m_req;
  int         run [8];
  logic       run_val [8];

  // A new level is accepted on the D-th consecutive edge that sees it
  // (after the 2-flop synchroniser) differing from the debounced level.
  task automatic model_step(input logic r, input logic [7:0] raw, input logic [7:0] c);
    logic [7:0] n_db, n_ri, n_fa;
    logic       sv;
    if (r) begin
      m_s1 = '0; m_s2 = '0; m_db = '0; m_rise = '0; m_fall = '0; m_req = '0;
      for (int i = 0; i < 8; i++) begin
        run[i] = 0;
        run_val[i] = 1'b0;
      end
    end else begin
      n_db = m_db;
      n_ri = '0;
      n_fa = '0;
      for (int i = 0; i < 8; i++) begin
        sv = m_s2[i];
        if (sv == run_val[i]) begin
          if (run[i] < 1000) run[i]++;
        end else begin
          run_val[i] = sv;
          run[i] = 1;
        end
        if (sv != m_db[i] && run[i] >= int'(D)) begin
          n_db[i] = sv;
          n_ri[i] = sv;
          n_fa[i] = ~sv;
        end
      end
      m_req  = m_rise | (~c & m_req);
      m_db   = n_db;
      m_rise = n_ri;
      m_fall = n_fa;
      m_s2   = m_s1;
      m_s1   = raw;
    end
  endtask

  task automatic tick(input logic r, input logic [7:0] raw, input logic [7:0] c);
    exp_t e;
    rst = r;
    raw_in = raw;
    clr = c;
    model_step(r, raw, c);
    e.db = m_db;
    e.ri = m_rise;
    e.fa = m_fall;
    e.rq = m_req;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Scoreboard consumer: one prediction per clock edge.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_eq("sb_db_out", db_out, e.db);
      check_eq("sb_rise", rise, e.ri);
      check_eq("sb_fall", fall, e.fa);
      check_eq("sb_req_latch", req_latch, e.rq);
      check_eq("sb_any_req", {7'b0, any_req}, {7'b0, |e.rq});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int n_rise3;

    // Reset with all raw inputs high.
    tick(1'b1, 8'hFF, 8'h00);
    check_eq("rst_db", db_out, 8'h00);
    tick(1'b1, 8'hFF, 8'h00);
    check_eq("rst_req", req_latch, 8'h00);
    tick(1'b0, 8'hFF, 8'h00);
    check_eq("rst_rel_db", db_out, 8'h00);
    check_eq("rst_rel_any", {7'b0, any_req}, 8'h00);
    for (int k = 0; k < 8; k++) tick(1'b0, 8'h00, 8'h00);

    // Clean press on channel 0.
    for (int k = 1; k <= 7; k++) begin
      tick(1'b0, 8'h01, 8'h00);
      if (k == 5) check_eq("press_db5", db_out, 8'h00);
      if (k == 6) begin
        check_eq("press_db6", db_out, 8'h01);
        check_eq("press_rise6", rise, 8'h01);
      end
      if (k == 7) begin
        check_eq("press_rise7", rise, 8'h00);
        check_eq("press_req", req_latch, 8'h01);
        check_eq("press_any", {7'b0, any_req}, 8'h01);
      end
    end

    // Bouncing press on channel 3: 3 high, 1 low, then held high.
    n_rise3 = 0;
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 8'h09, 8'h00);
      n_rise3 += int'(rise[3]);
    end
    tick(1'b0, 8'h01, 8'h00);
    n_rise3 += int'(rise[3]);
    check_eq("bounce_burst_db", db_out, 8'h01);
    for (int k = 1; k <= 9; k++) begin
      tick(1'b0, 8'h09, 8'h00);
      n_rise3 += int'(rise[3]);
      if (k == 5) check_eq("bounce_db5", db_out, 8'h01);
      if (k == 6) check_eq("bounce_db6", db_out, 8'h09);
    end
    check_eq("bounce_rise_count", 8'(n_rise3), 8'd1);

    // Release channel 0.
    for (int k = 1; k <= 7; k++) begin
      tick(1'b0, 8'h08, 8'h00);
      if (k == 5) check_eq("rel_db5", db_out, 8'h09);
      if (k == 6) begin
        check_eq("rel_db6", db_out, 8'h08);
        check_eq("rel_fall6", fall, 8'h01);
      end
      if (k == 7) begin
        check_eq("rel_fall7", fall, 8'h00);
        check_eq("rel_req", req_latch, 8'h09);
      end
    end

    // Channel 7 press; clear of an idle channel has no effect.
    tick(1'b0, 8'h88, 8'h40);
    check_eq("clr_idle_req", req_latch, 8'h09);
    for (int k = 2; k <= 6; k++) tick(1'b0, 8'h88, 8'h00);
    check_eq("race_rise", rise, 8'h80);
    tick(1'b0, 8'h88, 8'h80);  // clear during the rise pulse: set wins
    check_eq("race_req", req_latch, 8'h89);
    tick(1'b0, 8'h88, 8'h00);
    tick(1'b0, 8'h88, 8'h80);
    check_eq("clr_req", req_latch, 8'h09);

    // Reset in the middle of a channel 5 debounce window.
    for (int k = 0; k < 4; k++) tick(1'b0, 8'hA8, 8'h00);
    tick(1'b1, 8'hA8, 8'h00);
    check_eq("midrst_db", db_out, 8'h00);
    check_eq("midrst_req", req_latch, 8'h00);
    for (int k = 1; k <= 8; k++) begin
      tick(1'b0, 8'hA8, 8'h00);
      if (k == 5) check_eq("midrst_db5", db_out, 8'h00);
      if (k == 6) begin
        check_eq("midrst_db6", db_out, 8'hA8);
        check_eq("midrst_rise6", rise, 8'hA8);
      end
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
